// File: rtl/control_fsm.sv
// Multicycle main controller for the RV32I-subset core: sequences fetch/decode/execute/memory/writeback.
// Build macro BRANCH_NE_EN adds bne (funct3 001) to the supported branches; default build is beq only.
module control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       EQ,
  input  logic       mem_ready,
  output logic [2:0] ALUctrl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_alu_f3_ok;
  logic       w_mem_f3_ok;
  logic       w_br_f3_ok;
  logic       w_br_take;
  logic [2:0] w_alu_op;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Instruction-field decode shared by DECODE legality checks and execute/branch states
  always_comb begin
    w_alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                  (funct3 == 3'b110) || (funct3 == 3'b111);
    w_mem_f3_ok = (funct3 == 3'b010);
`ifdef BRANCH_NE_EN
    w_br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
    w_br_take   = (funct3 == 3'b001) ? ~EQ : EQ;
`else
    w_br_f3_ok  = (funct3 == 3'b000);
    w_br_take   = EQ;
`endif
    case (funct3)
      3'b000:  w_alu_op = ((r_state == S_EXECR) && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_op = ALU_SLT;
      3'b110:  w_alu_op = ALU_OR;
      3'b111:  w_alu_op = ALU_AND;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  // Next state and control outputs; reset forces every output to zero
  always_comb begin
    w_next    = r_state;
    ALUctrl   = ALU_ADD;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_I;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
          if (mem_ready) w_next = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          w_next  = S_FETCH;
          case (op)
            OP_LOAD: begin
              if (w_mem_f3_ok) w_next = S_MEMADR;
              else             illegal = 1'b1;
            end
            OP_STORE: begin
              ImmSrc = IMM_S;
              if (w_mem_f3_ok) w_next = S_MEMADR;
              else             illegal = 1'b1;
            end
            OP_RTYPE: begin
              if (w_alu_f3_ok) w_next = S_EXECR;
              else             illegal = 1'b1;
            end
            OP_ITYPE: begin
              if (w_alu_f3_ok) w_next = S_EXECI;
              else             illegal = 1'b1;
            end
            OP_BRANCH: begin
              ImmSrc = IMM_B;
              if (w_br_f3_ok) w_next = S_BRANCH;
              else            illegal = 1'b1;
            end
            OP_JAL: begin
              ImmSrc = IMM_J;
              w_next = S_JAL;
            end
            default: illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          w_next  = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          AdrSrc = 1'b1;
          if (mem_ready) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = RES_MDR;
          RegWrite  = 1'b1;
          w_next    = S_FETCH;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          if (mem_ready) w_next = S_FETCH;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUctrl = w_alu_op;
          w_next  = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUctrl = w_alu_op;
          w_next  = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA = SRCA_RS1;
          ALUctrl = ALU_SUB;
          PCWrite = w_br_take;
          w_next  = S_FETCH;
        end
        S_JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
          w_next  = S_ALUWB;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-instruction expected step sequences built from the
// instruction-level rules, walked cycle by cycle with randomized memory waits and EQ.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       EQ;
  logic       mem_ready;
  logic [2:0] ALUctrl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal;

  control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .EQ(EQ),
    .mem_ready(mem_ready), .ALUctrl(ALUctrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] a, b, res, imm;
    logic       adr, irw, pcw, memw, regw, ill;
  } ctl_t;

  // One cycle of an instruction: outputs, whether it waits on memory, and how PCWrite is derived
  typedef struct packed {
    ctl_t       c;
    logic       wt;
    logic       rdy_we;
    logic [1:0] pcm;
  } step_t;

`ifdef BRANCH_NE_EN
  localparam bit NE_EN = 1'b1;
`else
  localparam bit NE_EN = 1'b0;
`endif

  ctl_t  obs;
  step_t plan_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  assign obs = {ALUctrl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t mk(input logic [2:0] alu, input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] res, input logic [1:0] imm, input logic adr,
                              input logic pcw, input logic memw, input logic regw, input logic ill);
    ctl_t c;
    c.alu = alu; c.a = a; c.b = b; c.res = res; c.imm = imm;
    c.adr = adr; c.irw = 1'b0; c.pcw = pcw; c.memw = memw; c.regw = regw; c.ill = ill;
    return c;
  endfunction

  function automatic step_t st(input ctl_t c, input logic wt, input logic rdy_we, input logic [1:0] pcm);
    step_t s;
    s.c = c; s.wt = wt; s.rdy_we = rdy_we; s.pcm = pcm;
    return s;
  endfunction

  function automatic ctl_t fetch_ctl(input logic rdy);
    ctl_t c;
    c = mk(3'b000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    c.irw = rdy;
    c.pcw = rdy;
    return c;
  endfunction

  // Expected cycle sequence for one instruction, straight from the instruction-class rules
  task automatic build_plan(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    logic       ok;
    logic [1:0] imm;
    logic [2:0] alu;
    ctl_t       wb;
    case (f3)
      3'b010:  alu = 3'b101;
      3'b110:  alu = 3'b011;
      3'b111:  alu = 3'b010;
      default: alu = 3'b000;
    endcase
    imm = 2'b00;
    ok  = 1'b0;
    case (o)
      7'b0000011: ok = (f3 == 3'b010);
      7'b0100011: begin ok = (f3 == 3'b010); imm = 2'b01; end
      7'b0110011, 7'b0010011: ok = f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
      7'b1100011: begin ok = (f3 == 3'b000) || (NE_EN && f3 == 3'b001); imm = 2'b10; end
      7'b1101111: begin ok = 1'b1; imm = 2'b11; end
      default:    ok = 1'b0;
    endcase
    wb = mk(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    plan_q.delete();
    plan_q.push_back(st(fetch_ctl(1'b0), 1'b1, 1'b1, 2'd0));
    plan_q.push_back(st(mk(3'b000, 2'b01, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, ~ok),
                        1'b0, 1'b0, 2'd0));
    if (ok) begin
      case (o)
        7'b0000011: begin
          plan_q.push_back(st(mk(3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 2'd0));
          plan_q.push_back(st(mk(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 2'd0));
          plan_q.push_back(st(mk(3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 2'd0));
        end
        7'b0100011: begin
          plan_q.push_back(st(mk(3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 2'd0));
          plan_q.push_back(st(mk(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 2'd0));
        end
        7'b0110011: begin
          plan_q.push_back(st(mk((f3 == 3'b000 && f7) ? 3'b001 : alu, 2'b10, 2'b00, 2'b00, 2'b00,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 2'd0));
          plan_q.push_back(st(wb, 1'b0, 1'b0, 2'd0));
        end
        7'b0010011: begin
          plan_q.push_back(st(mk(alu, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 2'd0));
          plan_q.push_back(st(wb, 1'b0, 1'b0, 2'd0));
        end
        7'b1100011: begin
          plan_q.push_back(st(mk(3'b001, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                              1'b0, 1'b0, (f3 == 3'b001) ? 2'd2 : 2'd1));
        end
        default: begin
          plan_q.push_back(st(mk(3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 2'd0));
          plan_q.push_back(st(wb, 1'b0, 1'b0, 2'd0));
        end
      endcase
    end
  endtask

  task automatic tick(input logic r, input logic rdy, input logic eq);
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; EQ = eq;
    @(negedge clk);
  endtask

  // Walk one instruction; rnd=0 gives immediate fetch and dstall waits in the data-memory step
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input bit rnd, input int dstall, input logic eq_v, input bit idle_after);
    step_t s;
    ctl_t  e;
    logic  rdy, eq;
    int    k, stalls, dleft, rw_seen, rw_exp;
    build_plan(o, f3, f7);
    k = 0; stalls = 0; dleft = dstall; rw_seen = 0; rw_exp = 0;
    while (k < plan_q.size()) begin
      s = plan_q[k];
      if (s.wt) begin
        if (rnd)                      rdy = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
        else if (s.rdy_we || dleft == 0) rdy = 1'b1;
        else begin rdy = 1'b0; dleft--; end
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      eq = rnd ? 1'($urandom_range(0, 1)) : eq_v;
      @(posedge clk);
      #1;
      rst = 1'b0; op = o; funct3 = f3; funct7b5 = f7; mem_ready = rdy; EQ = eq;
      @(negedge clk);
      e = s.c;
      if (s.rdy_we) begin e.irw = rdy; e.pcw = rdy; end
      if (s.pcm == 2'd1)      e.pcw = eq;
      else if (s.pcm == 2'd2) e.pcw = ~eq;
      check($sformatf("%s[%0d]", tag, k), 32'(obs), 32'(e));
      if (RegWrite) rw_seen++;
      if (e.regw)   rw_exp++;
      if (!s.wt || rdy) begin k++; stalls = 0; end
      else stalls++;
    end
    check({tag, " regwrite count"}, 32'(rw_seen), 32'(rw_exp));
    if (idle_after) begin
      tick(1'b0, 1'b0, 1'b0);
      check({tag, " back in fetch"}, 32'(obs), 32'(fetch_ctl(1'b0)));
    end
  endtask

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return 7'b0000011;
      1:       return 7'b0100011;
      2:       return 7'b0110011;
      3:       return 7'b0010011;
      4:       return 7'b1100011;
      5:       return 7'b1101111;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  function automatic logic [2:0] pick_f3(input logic [6:0] o);
    logic [2:0] good [4];
    good = '{3'b000, 3'b010, 3'b110, 3'b111};
    if ($urandom_range(0, 4) == 0) return 3'($urandom_range(0, 7));
    case (o)
      7'b0000011, 7'b0100011: return 3'b010;
      7'b0110011, 7'b0010011: return good[$urandom_range(0, 3)];
      7'b1100011:             return 3'($urandom_range(0, 1));
      default:                return 3'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    logic [6:0] ro;
    rst = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; EQ = 1'b1; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(obs), 32'(0));
    tick(1'b0, 1'b0, 1'b0);
    check("post-reset fetch", 32'(obs), 32'(fetch_ctl(1'b0)));

    run_instr("sub",        7'b0110011, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    run_instr("lw wait2",   7'b0000011, 3'b010, 1'b0, 1'b0, 2, 1'b0, 1'b1);
    run_instr("sw",         7'b0100011, 3'b010, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    run_instr("beq taken",  7'b1100011, 3'b000, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    run_instr("beq not",    7'b1100011, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_instr("f3 001 br",  7'b1100011, 3'b001, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_instr("op zero",    7'b0000000, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_instr("jal",        7'b1101111, 3'b101, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_instr("addi bad f3", 7'b0010011, 3'b001, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Reset arriving while a store waits on memory
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    check("rstmw fetch", 32'(obs), 32'(fetch_ctl(1'b1)));
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("rstmw memwrite", 32'(obs),
          32'(mk(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    tick(1'b1, 1'b0, 1'b0);
    check("rstmw in reset", 32'(obs), 32'(0));
    tick(1'b0, 1'b0, 1'b0);
    check("rstmw fetch after", 32'(obs), 32'(fetch_ctl(1'b0)));

    for (int i = 0; i < 300; i++) begin
      ro = pick_op();
      run_instr($sformatf("rnd%0d", i), ro, pick_f3(ro), 1'($urandom_range(0, 1)),
                1'b1, 0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
